alu_muldiv_seq: RTL and testbench

Multi-cycle sequencer that executes MUL (low 32 bits), DIVU and REMU by iterating on the CPU's single shared ALU with its ADD and SUB encodings. It sits between the execute stage and the ALU. While idle it forwards the pipeline's ALU operands and control straight through. While running it owns the ALU, and the pipeline stalls on Busy.

---
 rtl/alu_muldiv_seq.sv | 162 ++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle MUL / DIVU / REMU sequencer that borrows the
// CPU's shared ALU (ADD and SUB encodings only). It passes the pipeline's ALU
// operands straight through while idle and takes over the ALU while running.
module alu_muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result,
  input  logic [31:0] PipeSrcA,
  input  logic [31:0] PipeSrcB,
  input  logic [4:0]  PipeALUControl,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  output logic [4:0]  ALUControl,
  input  logic [31:0] ALUResult,
  input  logic        Negative,
  input  logic        Zero
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b11110;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic [1:0]  op_q;

  // Multiply datapath
  logic [31:0] acc, mcand, mplier;
  // Divide datapath
  logic [31:0] rem, quot, divisor;

  logic        accept;
  logic        last;
  logic        is_mul;

  logic [32:0] sh;
  logic        hi;
  logic        borrow;
  logic [31:0] seq_a, seq_b;
  logic [4:0]  seq_ctrl;
  logic [31:0] rem_next, quot_next;

  // Zero flag from the ALU is not needed by this algorithm.
  logic        unused_zero;
  assign unused_zero = Zero;

  // A start request is honoured only outside RUN and only for a defined op.
  assign accept = (state != RUN) && Start && (Op != OP_RSV);
  assign last   = (count == 5'd31);
  assign is_mul = (op_q == OP_MUL);

  // Per-iteration operands, ALU command and restoring-divide decision.
  always_comb begin
    sh        = {rem, quot[31]};
    hi        = sh[32];
    seq_a     = is_mul ? acc : sh[31:0];
    seq_b     = is_mul ? (mplier[0] ? mcand : 32'd0) : divisor;
    seq_ctrl  = is_mul ? ALU_ADD : ALU_SUB;
    // Unsigned borrow of seq_a - seq_b, rebuilt from the ALU sign flag. A set
    // Hi bit means the 33-bit partial remainder already exceeds any divisor.
    borrow    = !hi & ((!seq_a[31] & seq_b[31]) |
                       (!(seq_a[31] ^ seq_b[31]) & Negative));
    rem_next  = borrow ? sh[31:0] : ALUResult;
    quot_next = {quot[30:0], !borrow};
  end

  // ALU mux: pass-through except while running; reset reclaims the ALU at once.
  always_comb begin
    SrcA       = PipeSrcA;
    SrcB       = PipeSrcB;
    ALUControl = PipeALUControl;
    if (state == RUN && !reset) begin
      SrcA       = seq_a;
      SrcB       = seq_b;
      ALUControl = seq_ctrl;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: state_next = accept ? RUN : IDLE;
      RUN: begin
        Busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        Done       = 1'b1;
        state_next = accept ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, one shift-add / shift-subtract step per RUN cycle, and
  // the result latch on the final iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      op_q    <= OP_MUL;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
      Result  <= '0;
    end else if (state == RUN) begin
      count <= count + 5'd1;
      if (is_mul) begin
        acc    <= ALUResult;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end else begin
        rem  <= rem_next;
        quot <= quot_next;
      end
      if (last) begin
        case (op_q)
          OP_MUL:  Result <= ALUResult;
          OP_DIVU: Result <= quot_next;
          OP_REMU: Result <= rem_next;
          default: Result <= Result;
        endcase
      end
    end else if (accept) begin
      op_q  <= Op;
      count <= '0;
      if (Op == OP_MUL) begin
        acc    <= '0;
        mcand  <= OpA;
        mplier <= OpB;
      end else begin
        rem     <= '0;
        quot    <= OpA;
        divisor <= OpB;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a small behavioural ALU attached.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OpA, OpB;
  logic        Busy, Done;
  logic [31:0] Result;
  logic [31:0] PipeSrcA, PipeSrcB;
  logic [4:0]  PipeALUControl;
  logic [31:0] SrcA, SrcB;
  logic [4:0]  ALUControl;
  logic [31:0] ALUResult;
  logic        Negative, Zero;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] MUL = 2'b00, DIVU = 2'b01, REMU = 2'b10, RSV = 2'b11;
  localparam logic [4:0] ADD = 5'b00010, SUB = 5'b11110;

  always #5 clk = ~clk;

  // Shared ALU as seen by the CPU: ADD, SUB, anything else XOR.
  always_comb begin
    if (ALUControl == ADD)      ALUResult = SrcA + SrcB;
    else if (ALUControl == SUB) ALUResult = SrcA - SrcB;
    else                        ALUResult = SrcA ^ SrcB;
    Negative = ALUResult[31];
    Zero     = (ALUResult == 32'd0);
  end

  alu_muldiv_seq dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .Busy(Busy), .Done(Done), .Result(Result),
    .PipeSrcA(PipeSrcA), .PipeSrcB(PipeSrcB), .PipeALUControl(PipeALUControl),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .ALUResult(ALUResult), .Negative(Negative), .Zero(Zero)
  );

  // Drive a start request from a negedge; it is accepted at the next posedge.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    @(posedge clk);
    #1;
    Start = 1'b0; OpA = 32'hDEADBEEF; OpB = 32'hCAFEF00D;
  endtask

  // Sample on negedges until Done (bounded), recording latency and busy cycles.
  task automatic wait_done(input logic [4:0] exp_ctrl, output int lat, output int busy_n,
                           output int bad_ctrl, output logic [31:0] res);
    lat = 0; busy_n = 0; bad_ctrl = 0; res = 32'hxxxxxxxx;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (Busy) begin
        busy_n++;
        if (ALUControl !== exp_ctrl) bad_ctrl++;
      end
      if (Done) begin
        res = Result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", Done); end
    checks++; if (Result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", Result); end
    reset = 1'b0;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    PipeSrcA = 32'd10; PipeSrcB = 32'd5; PipeALUControl = ADD;
    #1;
    checks++; if (SrcA !== 32'd10) begin errors++; $display("FAIL pass_srca got %h want 0000000a", SrcA); end
    checks++; if (SrcB !== 32'd5) begin errors++; $display("FAIL pass_srcb got %h want 00000005", SrcB); end
    checks++; if (ALUControl !== ADD) begin errors++; $display("FAIL pass_ctrl got %b want 00010", ALUControl); end
    // Odd pipe values for the runs that follow; they must not leak into RUN.
    PipeSrcA = 32'h13579BDF; PipeSrcB = 32'h2468ACE0; PipeALUControl = 5'b10101;
  endtask

  task automatic test_mul();
    int lat, bn, bad; logic [31:0] r;
    @(negedge clk);
    launch(MUL, 32'd7, 32'd6);
    wait_done(ADD, lat, bn, bad, r);
    checks++; if (r !== 32'd42) begin errors++; $display("FAIL mul_7x6 got %h want 0000002a", r); end
    checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency got %0d want 33", lat); end
    checks++; if (bn != 32) begin errors++; $display("FAIL mul_busy_cycles got %0d want 32", bn); end
    checks++; if (bad != 0) begin errors++; $display("FAIL mul_aluctrl bad cycles %0d want 0", bad); end
    @(negedge clk);
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL done_pulse got %0b want 0", Done); end
    checks++; if (Result !== 32'd42) begin errors++; $display("FAIL result_hold got %h want 0000002a", Result); end
    launch(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(ADD, lat, bn, bad, r);
    checks++; if (r !== 32'h00000001) begin errors++; $display("FAIL mul_ffff got %h want 00000001", r); end
    @(negedge clk);
    launch(MUL, 32'h00010000, 32'h00010000);
    wait_done(ADD, lat, bn, bad, r);
    checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL mul_wrap got %h want 00000000", r); end
  endtask

  task automatic test_div();
    int lat, bn, bad; logic [31:0] r;
    @(negedge clk);
    launch(DIVU, 32'd100, 32'd7);
    wait_done(SUB, lat, bn, bad, r);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h want 0000000e", r); end
    checks++; if (bad != 0) begin errors++; $display("FAIL div_aluctrl bad cycles %0d want 0", bad); end
    @(negedge clk);
    launch(REMU, 32'd100, 32'd7);
    wait_done(SUB, lat, bn, bad, r);
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %h want 00000002", r); end
    @(negedge clk);
    launch(DIVU, 32'hFFFFFFFF, 32'd1);
    wait_done(SUB, lat, bn, bad, r);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_max_1 got %h want ffffffff", r); end
    @(negedge clk);
    launch(REMU, 32'h80000000, 32'hFFFFFFFF);
    wait_done(SUB, lat, bn, bad, r);
    checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL remu_hi got %h want 80000000", r); end
  endtask

  task automatic test_divzero();
    int lat, bn, bad; logic [31:0] r;
    @(negedge clk);
    launch(DIVU, 32'h1234, 32'd0);
    wait_done(SUB, lat, bn, bad, r);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_by0 got %h want ffffffff", r); end
    checks++; if (lat != 33) begin errors++; $display("FAIL divu_by0_latency got %0d want 33", lat); end
    @(negedge clk);
    launch(REMU, 32'h1234, 32'd0);
    wait_done(SUB, lat, bn, bad, r);
    checks++; if (r !== 32'h00001234) begin errors++; $display("FAIL remu_by0 got %h want 00001234", r); end
  endtask

  task automatic test_ignored();
    int lat, bn, bad; logic [31:0] r;
    @(negedge clk);
    launch(RSV, 32'd9, 32'd9);
    @(negedge clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL op11_busy got %0b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL op11_done got %0b want 0", Done); end
    // A second request in the middle of a MUL must not disturb it.
    launch(MUL, 32'd7, 32'd6);
    repeat (5) @(negedge clk);
    Start = 1'b1; Op = DIVU; OpA = 32'd1000; OpB = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    wait_done(ADD, lat, bn, bad, r);
    checks++; if (r !== 32'd42) begin errors++; $display("FAIL run_start_result got %h want 0000002a", r); end
    checks++; if (lat != 27) begin errors++; $display("FAIL run_start_latency got %0d want 27", lat); end
  endtask

  task automatic test_reset_mid();
    int lat, bn, bad; logic [31:0] r;
    @(negedge clk);
    launch(DIVU, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    PipeSrcA = 32'h00000055; PipeSrcB = 32'h000000AA; PipeALUControl = 5'b01100;
    #1;
    checks++; if (SrcA !== 32'h55) begin errors++; $display("FAIL rst_pass_srca got %h want 00000055", SrcA); end
    checks++; if (ALUControl !== 5'b01100) begin errors++; $display("FAIL rst_pass_ctrl got %b want 01100", ALUControl); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %0b want 0", Done); end
    checks++; if (Result !== 32'd0) begin errors++; $display("FAIL rst_mid_result got %h want 0", Result); end
    checks++; if (SrcB !== 32'hAA) begin errors++; $display("FAIL rst_mid_srcb got %h want 000000aa", SrcB); end
    launch(DIVU, 32'd100, 32'd7);
    wait_done(SUB, lat, bn, bad, r);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL post_rst_divu got %h want 0000000e", r); end
    checks++; if (lat != 33) begin errors++; $display("FAIL post_rst_latency got %0d want 33", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, bn, bad; logic [31:0] r;
    @(negedge clk);
    launch(MUL, 32'd7, 32'd6);
    wait_done(ADD, lat, bn, bad, r);
    checks++; if (r !== 32'd42) begin errors++; $display("FAIL b2b_first got %h want 0000002a", r); end
    // Still inside the DONE cycle: request the next op.
    launch(DIVU, 32'd100, 32'd7);
    wait_done(SUB, lat, bn, bad, r);
    checks++; if (r !== 32'd14) begin errors++; $display("FAIL b2b_second got %h want 0000000e", r); end
    checks++; if (lat != 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
    checks++; if (bn != 32) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 32", bn); end
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; Op = MUL; OpA = '0; OpB = '0;
    PipeSrcA = '0; PipeSrcB = '0; PipeALUControl = '0;
    test_reset();
    test_passthrough();
    test_mul();
    test_div();
    test_divzero();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
